regfile_alu_sequencer: RTL

Multi-cycle execute/write-back sequencer that sits directly in front of the 32x32 file register. It accepts one register-to-register command at a time, drives the register file's two read ports and captures the operands. It then computes the result, either in a single cycle or with an iterative 32-step multiply, and writes it back through the file register's write port. It is the first block that exercises the file register as a datapath component rather than from a bench.

---
 rtl/seq_pkg.sv | 31 +++
 rtl/seq_multiplier.sv | 95 +++++++++
 rtl/regfile_alu_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the register-file execute/write-back sequencer:
//   - default datapath widths (DATA_W_DEF, ADDR_W_DEF)
//   - opcode encodings OP_ADD..OP_MUL
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } state_t;

endpackage : seq_pkg

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier returning the low DATA_W bits of a*b.
// One bit of b is consumed per cycle, LSB first; DATA_W must be a power of 2.
// The first step is taken on the edge that accepts start, so the last step
// (and done) falls exactly DATA_W cycles after start is first raised.
//
// Ports:
//   clk      in   system clock
//   rst_all  in   asynchronous active-low reset
//   start    in   begin a multiply with a/b (ignored while busy)
//   a, b     in   operands, sampled only on the start cycle
//   busy     out  steps 2..DATA_W are in progress
//   done     out  one-cycle pulse during the final step; product valid then
//   product  out  running/final product (final value valid with done)
// -----------------------------------------------------------------------------
module seq_multiplier
    import seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_all,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;      // steps already completed
    logic              busy_q, busy_d;

    logic              load;
    logic [DATA_W-1:0] cur_acc, cur_mcand, cur_mplier;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can leave
        // it unassigned and infer a latch.
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done     = 1'b0;

        load       = start && !busy_q;
        // On the start cycle the step works straight from the inputs.
        cur_acc    = load ? '0 : acc_q;
        cur_mcand  = load ? a  : mcand_q;
        cur_mplier = load ? b  : mplier_q;
        product    = cur_acc + (cur_mplier[0] ? cur_mcand : '0);

        if (load || busy_q) begin
            acc_d    = product;
            mcand_d  = cur_mcand << 1;
            mplier_d = cur_mplier >> 1;
            if (busy_q && cnt_q == CNT_W'(DATA_W - 1)) begin
                done   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                busy_d = 1'b1;
                cnt_d  = load ? CNT_W'(1) : cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_all) begin
        if (!rst_all) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule : seq_multiplier

// File: rtl/regfile_alu_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_alu_sequencer
// Executes one register-to-register command at a time against an external
// 2-read/1-write register file: IDLE -> READ -> EXEC -> WRITE -> IDLE.
// Single-cycle ops spend one cycle in EXEC; MUL spends DATA_W cycles there.
//
// Ports:
//   clk, rst_all               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/cmd_rd/cmd_rs/cmd_rt command fields, latched on accept
//   read0_addr/read1_addr      register file read addresses (latched rs/rt)
//   read0_data/read1_data      combinational register file read data
//   write_addr/write_data/we   register file write port (we only in WRITE, rd!=0)
//   done                       one-cycle pulse in the WRITE cycle
// -----------------------------------------------------------------------------
module regfile_alu_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_all,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    output logic [ADDR_W-1:0] read0_addr,
    output logic [ADDR_W-1:0] read1_addr,
    input  logic [DATA_W-1:0] read0_data,
    input  logic [DATA_W-1:0] read1_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              we,
    output logic              done
);

    localparam int SH_W = $clog2(DATA_W);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic              mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_all) begin
        if (!rst_all) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = READ;
            READ:  state_d = EXEC;
            EXEC:  if (op_q != OP_MUL || mul_done) state_d = WRITE;
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        // rst_all gating keeps ready low for the whole reset, not just after it.
        cmd_ready = (state_q == IDLE) && rst_all;
        done      = (state_q == WRITE);
        we        = (state_q == WRITE) && (waddr_q != '0);
        mul_start = (state_q == EXEC) && (op_q == OP_MUL) && !mul_busy;
    end

    assign accept = cmd_valid && cmd_ready;

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        alu_result = '0;
        unique case (op_q)
            OP_ADD: alu_result = a_q + b_q;
            OP_SUB: alu_result = a_q - b_q;
            OP_AND: alu_result = a_q & b_q;
            OP_OR:  alu_result = a_q | b_q;
            OP_XOR: alu_result = a_q ^ b_q;
            OP_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL: alu_result = a_q << b_q[SH_W-1:0];
            OP_MUL: alu_result = '0;   // produced by seq_multiplier
            default: alu_result = '0;
        endcase
    end

    seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst_all (rst_all),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // ---------------- datapath next-state ----------------
    always_comb begin
        op_d     = op_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        waddr_d  = waddr_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;

        if (accept) begin
            op_d = op_t'(cmd_op);
            rd_d = cmd_rd;
            rs_d = cmd_rs;
            rt_d = cmd_rt;
        end

        if (state_q == READ) begin
            a_d = read0_data;
            b_d = read1_data;
        end

        // Write-back registers change only on entry to WRITE, so they hold
        // their last values through the following IDLE/READ/EXEC cycles.
        if (state_q == EXEC && state_d == WRITE) begin
            result_d = (op_q == OP_MUL) ? mul_product : alu_result;
            waddr_d  = rd_q;
        end
    end

    // NOTE: all control and datapath flops are reset so a reset mid-command
    // leaves nothing stale on the register file interface.
    always_ff @(posedge clk or negedge rst_all) begin
        if (!rst_all) begin
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            waddr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            waddr_q  <= waddr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign read0_addr = rs_q;
    assign read1_addr = rt_q;
    assign write_addr = waddr_q;
    assign write_data = result_q;

endmodule : regfile_alu_sequencer
